alu_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle ALU. It accepts one operation per cycle through a valid/ready input handshake and computes over configurable-width operands. It keeps an internal accumulator for chained operations and returns the result with zero, carry and overflow flags through a valid/ready output handshake. It sits between an operand source (sequencer or test driver) and a result sink that may apply backpressure.

---
 rtl/alu_pipe_pkg.sv | 32 +++
 rtl/alu_pipe_core.sv | 84 ++++++++
 rtl/alu_pipe.sv | 114 +++++++++++
 tb/tb_alu_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// alu_pipe shared types.
// Opcodes and flag bundle.
package alu_pipe_pkg;

  localparam int FLAG_W = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_NAND = 4'd6,
    OP_NOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MIN  = 4'd11,
    OP_MAX  = 4'd12,
    OP_ACC  = 4'd13,
    OP_CLR  = 4'd14,
    OP_PASS = 4'd15
  } op_t;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic zero;
  } flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// alu_pipe combinational datapath.
// (op, a, b, acc) -> (result, flags).
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw;
  logic             arith;
  logic             sub;
  logic             ovf;
  logic             carry;

  assign sh = b[SW-1:0];

  // adder shared by ADD, SUB and ACC
  always_comb begin
    sub   = (op == OP_SUB);
    arith = (op == OP_ADD) || sub ||
            (op == OP_ACC);
    x     = (op == OP_ACC) ? acc : a;
    y     = (op == OP_ACC) ? a : b;
    sum   = sub ? {1'b0, x} - {1'b0, y}
                : {1'b0, x} + {1'b0, y};
    ovf   = arith &&
            (sub ? (x[M] != y[M])
                 : (x[M] == y[M])) &&
            (sum[M] != x[M]);
    carry = arith && sum[WIDTH];
  end

  // opcode select, clamp, flags
  always_comb begin
    raw = '0;
    unique case (op)
      OP_ADD,
      OP_SUB,
      OP_ACC:  raw = sum[WIDTH-1:0];
      OP_AND:  raw = a & b;
      OP_OR:   raw = a | b;
      OP_XOR:  raw = a ^ b;
      OP_XNOR: raw = ~(a ^ b);
      OP_NAND: raw = ~(a & b);
      OP_NOR:  raw = ~(a | b);
      OP_SHL:  raw = a << sh;
      OP_SHR:  raw = a >> sh;
      OP_SRA:  raw = $signed(a) >>> sh;
      OP_MIN:  raw = ($signed(a) < $signed(b))
                     ? a : b;
      OP_MAX:  raw = ($signed(a) > $signed(b))
                     ? a : b;
      OP_CLR:  raw = '0;
      OP_PASS: raw = a;
      default: raw = '0;
    endcase
    result = raw;
    if (SAT_EN && ovf)
      result = x[M] ? SMIN : SMAX;
    flags.ovf   = ovf;
    flags.carry = carry;
    flags.zero  = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe top: S1/S2 registers,
// accumulator and handshakes.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_t               op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  logic             s1_valid_q, s1_valid_d;
  op_t              s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q,   s2_res_d;
  flags_t           s2_flags_q, s2_flags_d;
  logic [WIDTH-1:0] acc_q,      acc_d;

  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;

  alu_pipe_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .op     (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .acc    (acc_q),
    .result (core_res),
    .flags  (core_flags)
  );

  // handshakes and next-state
  always_comb begin
    s2_load  = s1_valid_q &&
               (!s2_valid_q || out_ready);
    in_ready = !rst &&
               (!s1_valid_q || s2_load);
    s1_load  = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op;
      s1_a_d     = a;
      s1_b_d     = b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_res_d   = core_res;
      s2_flags_d = core_flags;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    acc_d = acc_q;
    if (s2_load &&
        (s1_op_q == OP_ACC ||
         s1_op_q == OP_CLR))
      acc_d = core_res;
  end

  // pipeline and accumulator state
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_res_q;
  assign flags     = s2_flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// alu_pipe bench: directed steps plus
// random traffic vs. a reference model.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready, in_ready_s;
  op_t        op;
  logic [7:0] a, b;
  logic       out_valid, out_valid_s;
  logic       out_ready;
  logic [7:0] result, result_s;
  logic [2:0] flags, flags_s;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .SAT_EN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  alu_pipe #(.WIDTH(8), .SAT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid_s),
    .out_ready(out_ready),
    .result(result_s), .flags(flags_s)
  );

  typedef struct {
    int         r0;
    logic [2:0] f0;
    int         r1;
    logic [2:0] f1;
  } exp_t;

  exp_t       q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         n_pop = 0;
  int         acc0 = 0, acc1 = 0;
  logic [7:0] ov_hist = '0;
  logic [7:0] last_res, last_res_s;
  logic [2:0] last_fl, last_fl_s;
  logic       hold = 1'b0;
  logic [7:0] h_res;
  logic [2:0] h_fl;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // plain-integer model of one op
  function automatic void model(
    input int op_i, input int av,
    input int bv, input int accv,
    input bit sat, output int r,
    output logic [2:0] fl);
    int s; bit c, v, ar;
    s = 0; c = 0; v = 0; r = 0; ar = 0;
    case (op_i)
      0: begin
        r = (av + bv) & 255;
        c = (av + bv) > 255;
        s = sx(av) + sx(bv); ar = 1;
      end
      1: begin
        r = (av - bv) & 255;
        c = av < bv;
        s = sx(av) - sx(bv); ar = 1;
      end
      13: begin
        r = (accv + av) & 255;
        c = (accv + av) > 255;
        s = sx(accv) + sx(av); ar = 1;
      end
      2:  r = av & bv;
      3:  r = av | bv;
      4:  r = av ^ bv;
      5:  r = ~(av ^ bv) & 255;
      6:  r = ~(av & bv) & 255;
      7:  r = ~(av | bv) & 255;
      8:  r = (av << (bv % 8)) & 255;
      9:  r = av >> (bv % 8);
      10: r = (sx(av) >>> (bv % 8)) & 255;
      11: r = (sx(av) < sx(bv)) ? av : bv;
      12: r = (sx(av) > sx(bv)) ? av : bv;
      14: r = 0;
      default: r = av;
    endcase
    if (ar) v = (s > 127) || (s < -128);
    if (sat && v) r = (s > 0) ? 127 : 128;
    fl = {v, c, r == 0};
  endfunction

  // scoreboard, hold check, history
  always @(negedge clk) begin
    exp_t e;
    ov_hist = {ov_hist[6:0], out_valid};
    if (rst) begin
      q.delete();
      acc0 = 0; acc1 = 0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_res", result, h_res);
        chk("hold_flg", flags, h_fl);
      end
      if (out_valid && out_ready) begin
        n_assert++;
        assert (q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexp_out: got %0h want none",
                 result);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("res", result, e.r0);
          chk("flg", flags, e.f0);
          chk("vld_sat", out_valid_s, 1);
          chk("res_sat", result_s, e.r1);
          chk("flg_sat", flags_s, e.f1);
          last_res = result;
          last_fl = flags;
          last_res_s = result_s;
          last_fl_s = flags_s;
          n_pop++;
        end
      end
      hold = out_valid && !out_ready;
      h_res = result;
      h_fl = flags;
      if (in_valid && in_ready) begin
        chk("rdy_sat", in_ready_s, 1);
        model(int'(op), a, b, acc0, 0,
              e.r0, e.f0);
        model(int'(op), a, b, acc1, 1,
              e.r1, e.f1);
        if (op == OP_ACC || op == OP_CLR) begin
          acc0 = e.r0;
          acc1 = e.r1;
        end
        q.push_back(e);
      end
    end
  end

  // offer one op until accepted
  task automatic send(input op_t o,
                      input logic [7:0] av,
                      input logic [7:0] bv);
    int k = 0;
    op = o; a = av; b = bv;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 50);
    n_assert++;
    assert (k < 50) else begin
      n_fail++;
      $error("FAIL send_tmo: got %0d want <50", k);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // wait until all results are out
  task automatic drain;
    int k = 0;
    while ((q.size() != 0 || out_valid)
           && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    n_assert++;
    assert (k < 60) else begin
      n_fail++;
      $error("FAIL drain_tmo: got %0d want <60", k);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0;
    out_ready = 1'b1; op = OP_PASS;
    a = '0; b = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_flg", flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(OP_ADD, 8'hF0, 8'h20); drain;
    chk("add_res", last_res, 8'h10);
    chk("add_flg", last_fl, 3'b010);

    send(OP_ADD, 8'h70, 8'h20); drain;
    chk("sat_res", last_res_s, 8'h7F);
    chk("sat_ovf", last_fl_s[2], 1);
    chk("nosat_res", last_res, 8'h90);

    send(OP_CLR, 8'h00, 8'h00);
    send(OP_ACC, 8'h05, 8'h00);
    send(OP_ACC, 8'h07, 8'h00);
    send(OP_ACC, 8'hFF, 8'h00);
    drain;
    chk("chain_gap", ov_hist[5:0], 6'b011110);
    chk("chain_res", last_res, 8'h0B);
    chk("chain_flg", last_fl, 3'b010);

    base = n_pop;
    out_ready = 1'b0;
    op = OP_ADD; a = 8'd1; b = 8'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rdy", in_ready, (i < 2) ? 1 : 0);
      if (i >= 2) begin
        chk("bp_vld", out_valid, 1);
        chk("bp_res", result, 8'd2);
      end
      @(posedge clk); #1;
      if (i < 2) a = a + 8'd1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_free", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(OP_ADD, 8'd4, 8'd1);
    send(OP_ADD, 8'd5, 8'd1);
    drain;
    chk("bp_cnt", n_pop - base, 5);
    chk("bp_last", last_res, 8'd6);

    send(OP_SRA, 8'h80, 8'h0B); drain;
    chk("sra", last_res, 8'hF0);
    send(OP_SHL, 8'h01, 8'h07); drain;
    chk("shl", last_res, 8'h80);
    send(OP_SHR, 8'h80, 8'h07); drain;
    chk("shr", last_res, 8'h01);
    send(OP_MIN, 8'h80, 8'h7F); drain;
    chk("min", last_res, 8'h80);
    send(OP_MAX, 8'h80, 8'h7F); drain;
    chk("max", last_res, 8'h7F);
    send(OP_SUB, 8'h05, 8'h05); drain;
    chk("sub_res", last_res, 8'h00);
    chk("sub_flg", last_fl, 3'b001);

    send(OP_CLR, 8'h00, 8'h00);
    send(OP_ACC, 8'h09, 8'h00);
    drain;
    chk("acc9", last_res, 8'h09);
    out_ready = 1'b0;
    send(OP_PASS, 8'h01, 8'h00);
    send(OP_ACC, 8'h04, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_rdy", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_vld", out_valid, 0);
    end
    chk("mrst_res", result, 0);
    chk("mrst_flg", flags, 0);
    @(posedge clk); #1;
    base = n_pop;
    send(OP_ACC, 8'h03, 8'h00); drain;
    chk("post_acc", last_res, 8'h03);
    chk("post_cnt", n_pop - base, 1);

    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      op = op_t'(4'($urandom % 16));
      a = 8'($urandom);
      b = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain;
    chk("final_q", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
